// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, multiply-unit FSM states, MULT/MULTU funct codes.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/adder32bit.sv
// 32-bit ripple-carry adder with carry-in and carry-out, shared across the datapath.
module adder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        cout
);

  logic carry;

  // NOTE: always_comb uses blocking '=' so the carry ripples bit to bit within one
  // evaluation; every output gets a value on every pass, so no latch is inferred.
  always_comb begin
    carry = ci;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mips_mult_unit.sv
// Iterative shift-add MULT/MULTU unit owning the HI/LO registers (MTHI/MTLO writes, MFHI/MFLO reads).
// Define MIPS_MULT_SIGNED_EN to build signed MULT support (NEG state and 64-bit negation).
module mips_mult_unit #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_pkg::*;

  mult_state_t      state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0] cnt;
  logic             launch, last_iter, run_to_done;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_ci, add_cout;
  logic [WIDTH-1:0] acc_next, mplier_next, mcand_in, mplier_in;

  assign launch      = start && !busy;
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
  assign acc_next    = {add_cout, add_sum[WIDTH-1:1]};
  assign mplier_next = {add_sum[0], mplier[WIDTH-1:1]};

  adder32bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .ci   (add_ci),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MIPS_MULT_SIGNED_EN
  logic             op_is_signed, op_neg;
  logic [WIDTH-1:0] hi_neg_sum;
  logic             hi_neg_cout_unused;

  // Magnitudes go through the unsigned datapath; 0x80000000 stays 0x80000000 as unsigned.
  assign mcand_in    = (op_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
  assign mplier_in   = (op_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;
  assign run_to_done = last_iter && !op_is_signed;

  // Upper word of the 64-bit negate takes the carry out of the lower-word negate.
  adder32bit u_hi_neg (
    .a    (~acc),
    .b    ('0),
    .ci   (add_cout),
    .sum  (hi_neg_sum),
    .cout (hi_neg_cout_unused)
  );
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign mcand_in         = rs;
  assign mplier_in        = rt;
  assign run_to_done      = last_iter;
`endif

  // The iteration adder doubles as the LO negator while in NEG.
  always_comb begin
    add_a  = acc;
    add_b  = mplier[0] ? mcand : '0;
    add_ci = 1'b0;
`ifdef MIPS_MULT_SIGNED_EN
    if (state == ST_NEG) begin
      add_a  = ~mplier;
      add_b  = '0;
      add_ci = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (run_to_done)    state_next = ST_DONE;
        else if (last_iter) state_next = ST_NEG;
      end
      ST_NEG: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef MIPS_MULT_SIGNED_EN
      op_is_signed <= 1'b0;
      op_neg       <= 1'b0;
`endif
    end else if (launch) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
`ifdef MIPS_MULT_SIGNED_EN
      op_is_signed <= op_signed;
      op_neg       <= op_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
`endif
    end else if (state == ST_RUN) begin
      acc    <= acc_next;
      mplier <= mplier_next;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // HI/LO change only on an idle MTHI/MTLO strobe or on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end else if (state == ST_RUN && run_to_done) begin
      hi <= acc_next;
      lo <= mplier_next;
    end
`ifdef MIPS_MULT_SIGNED_EN
    else if (state == ST_NEG) begin
      hi <= op_neg ? hi_neg_sum : acc;
      lo <= op_neg ? add_sum    : mplier;
    end
`endif
  end

endmodule

// File: tb/tb_mips_mult_unit.sv
// Directed self-checking bench for mips_mult_unit (signed cases follow MIPS_MULT_SIGNED_EN).
module tb_mips_mult_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op_signed, hi_we, lo_we;
  logic [31:0] rs, rt, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mult_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_signed (op_signed),
    .rs        (rs),
    .rt        (rt),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges from the current cycle until done is seen, capped so a stuck DUT cannot hang the run.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Drive start for one edge (E0); caller is #1 after an edge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    rs = a; rt = b; op_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mult(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
    int n;
    launch(sgn, a, b);
    check({tag, "_busy"}, busy, 1'b1);
    wait_done(n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n, pulses;
    start = 0; op_signed = 0; hi_we = 0; lo_we = 0;
    rs = '0; rt = '0; wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI then MTLO while idle
    hi_we = 1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 1'b0);
    lo_we = 1; wdata = 32'h5678;
    @(posedge clk); #1;
    lo_we = 0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);
    check("mtlo_busy", busy, 1'b0);

    // Strobes during RUN are dropped; HI/LO hold until completion
    launch(1'b0, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    start = 1; rs = 32'd100; rt = 32'd100;
    hi_we = 1; lo_we = 1; wdata = 32'hDEAD;
    @(posedge clk); #1;
    start = 0; hi_we = 0; lo_we = 0;
    check("midrun_hi_held", hi, 32'h1234);
    check("midrun_lo_held", lo, 32'h5678);
    check("midrun_busy", busy, 1'b1);
    wait_done(n);
    check("midrun_lat", n + 6, 32);
    check("midrun_hi", hi, 32'h0);
    check("midrun_lo", lo, 32'd63);
    @(posedge clk); #1;
    check("after_done_idle", {busy, done}, 2'b00);

    // start together with MTHI in the same idle cycle
    hi_we = 1; wdata = 32'hAAAA;
    launch(1'b0, 32'd3, 32'd5);
    hi_we = 0;
    check("start_mthi_hi", hi, 32'hAAAA);
    wait_done(n);
    check("multu_3x5_lat", n, 32);
    check("multu_3x5_hi", hi, 32'h0);
    check("multu_3x5_lo", lo, 32'hF);

    run_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);

    // New start accepted in the DONE cycle
    launch(1'b0, 32'd2, 32'h8000_0000);
    check("relaunch_busy", busy, 1'b1);
    wait_done(n);
    check("relaunch_lat", n, 32);
    check("relaunch_hi", hi, 32'h1);
    check("relaunch_lo", lo, 32'h0);
    @(posedge clk); #1;

`ifdef MIPS_MULT_SIGNED_EN
    run_mult("mult_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    run_mult("mult_min_x_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_mult("mult_m3x_m4", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 32'd12, 33);
`else
    run_mult("mult_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h2, 32'hFFFF_FFFA, 32);
    run_mult("mult_min_x_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32);
`endif
    @(posedge clk); #1;

    // Asynchronous reset mid-multiply
    launch(1'b0, 32'd11, 32'd13);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    #3 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_lo_kept", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
